add_tree_pipe: RTL and testbench
================================

ADD_TREE_PIPE -- requirements
Module: add_tree_pipe

Interface
REQ-001 Parameter N_IN, default 25, number of signed input lanes (2..64), excluding bias.
REQ-002 Parameter DW, default 16, lane, bias and output width in bits.
REQ-003 Parameter SAT, default 1; 1 = saturate the output, 0 = wrap the output.
REQ-004 Parameter ACC_GW, default 8, accumulator guard bits.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_vld  in  1  the input beat is valid this cycle.
REQ-008 in_first  in  1  the beat starts a new accumulation; sampled only when in_vld=1.
REQ-009 in_last  in  1  the beat ends the accumulation; sampled only when in_vld=1.
REQ-010 in_bus  in  N_IN*DW  packed signed lanes; lane k occupies bits [k*DW +: DW].
REQ-011 in_bias  in  DW  signed bias, summed as an extra lane.
REQ-012 out  out  DW  signed result.
REQ-013 out_vld  out  1  one-cycle pulse marking a valid out.
REQ-014 ovf  out  1  out was clipped (SAT=1) or wrapped (SAT=0); valid only while out_vld=1.

Function
REQ-015 Operands: N_IN lanes plus in_bias, for M = N_IN+1 operands, all two's complement.
REQ-016 Tree depth L = ceil(log2(M)); each level is a register stage of pairwise adds; an odd leftover operand passes through registered.
REQ-017 Level j adders are DW+j bits wide and sign-extend their operands; no overflow may occur inside the tree.
REQ-018 Stage L+1 is the accumulator, width DW+L+ACC_GW: on a valid beat, in_first=1 loads the tree sum; otherwise the tree sum is added to the accumulator.
REQ-019 Stage L+2 is the output register: on a valid beat with in_last=1, the rounded accumulator result is written to out and out_vld pulses.
REQ-020 Output conversion, SAT=1: the result clips to [-2^(DW-1), 2^(DW-1)-1] and ovf=1 on a clip.
REQ-021 Output conversion, SAT=0: out is the low DW bits of the result, and ovf=1 when those bits differ from the full value.
REQ-022 Latency from in_vld to the matching out_vld is L+2 cycles (7 for the defaults).
REQ-023 Throughput: one beat accepted every cycle; there is no back-pressure and no stall.
REQ-024 in_vld, in_first and in_last travel in a shift register alongside the data; a stage holding an invalid beat does not change the accumulator.
REQ-025 in_first=1 with in_last=1 yields a single-beat sum; this is plain adder-tree behaviour.
REQ-026 A valid beat with in_first=1 arriving before the previous group's in_last discards the open accumulation; no output is produced for the discarded group.
REQ-027 A group whose first beat arrives with in_first=0 after reset accumulates onto zero.
REQ-028 out and ovf hold their values between out_vld pulses.

Reset
REQ-029 rst=1 clears immediately: out=0, out_vld=0, ovf=0, all pipeline valid and first/last flags 0, accumulator 0.
REQ-030 Beats in flight when rst asserts are dropped, and no out_vld is generated for them after release.
REQ-031 The first beat is accepted on the first rising clk edge after rst deasserts.

Structure
REQ-032 Package add_tree_pkg holds the clog2 function, the saturate/wrap conversion function, and the default parameter constants.
REQ-033 One sub-module, add_tree_level (a registered pairwise-add level with valid passthrough), is instantiated L times with increasing width.

Verification (defaults unless stated; in_first=in_last=1 unless stated)
REQ-034 Lane k = k (k = 0..24), bias = 25: out = 325 (0x0145), ovf=0, out_vld exactly 7 cycles after in_vld.
REQ-035 Lane k = -k, bias = -25: out = -325 (0xFEBB); lanes 0..12 = -k, lanes 13..24 = k, bias = 25: out = 169.
REQ-036 All lanes and bias = 0x7FFF: SAT=1 gives out = 0x7FFF, ovf=1; SAT=0 gives out = 0xFFE6, ovf=1.
REQ-037 Three back-to-back beats of the REQ-034 data, first on beat 0, last on beat 2: one out_vld, out = 975; beats in_vld on consecutive cycles give out_vld on consecutive cycles.
REQ-038 rst pulses 3 cycles after a valid beat: no out_vld follows; a new beat after release gives the correct sum after 7 cycles.
REQ-039 N_IN=4, DW=8: lanes 1,2,3,4, bias 5: out = 15, latency L+2 = 5.

Source files
------------

// File: rtl/add_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package add_tree_pkg;

    localparam int N_IN_DEF   = 25;
    localparam int DW_DEF     = 16;
    localparam int SAT_DEF    = 1;
    localparam int ACC_GW_DEF = 8;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Operand count after j pairwise levels: ceil(m / 2^j).
    function automatic int ops_at(input int m, input int j);
        return (m + (1 << j) - 1) >> j;
    endfunction

    // Bit offset of level j inside the flattened tree bus (level 0 = inputs).
    function automatic int tree_off(input int m, input int dw, input int j);
        int s;
        s = 0;
        for (int i = 0; i < j; i++) begin
            s = s + ops_at(m, i) * (dw + i);
        end
        return s;
    endfunction

    // Narrow a wide signed value to dw bits; returns {ovf, value}.
    // Saturating mode clips, wrapping mode keeps the low bits and flags
    // any loss of information.
    function automatic logic [64:0] conv_out(input logic signed [127:0] v,
                                             input int dw, input logic sat);
        logic signed [127:0] maxv;
        logic signed [127:0] minv;
        logic signed [127:0] back;
        logic [63:0]         r;
        logic                o;
        maxv = (128'sd1 <<< (dw - 1)) - 128'sd1;
        minv = -maxv - 128'sd1;
        back = (v <<< (128 - dw)) >>> (128 - dw);
        if (sat) begin
            if (v > maxv) begin
                r = maxv[63:0];
                o = 1'b1;
            end else if (v < minv) begin
                r = minv[63:0];
                o = 1'b1;
            end else begin
                r = v[63:0];
                o = 1'b0;
            end
        end else begin
            r = v[63:0];
            o = (back != v);
        end
        return {o, r};
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of pairwise signed adds; an odd leftover operand
// is paired with zero so it passes through one bit wider.
module add_tree_level
    import add_tree_pkg::*;
#(
    parameter int N_OPS = 2,
    parameter int IW    = 16,
    localparam int N_RES = ops_at(N_OPS, 1),
    localparam int OW    = IW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [N_OPS*IW-1:0]   in_bus,
    output logic                  out_vld,
    output logic                  out_first,
    output logic                  out_last,
    output logic [N_RES*OW-1:0]   out_bus
);

    logic [2*N_RES*IW-1:0] pad;
    logic signed [IW-1:0]  a;
    logic signed [IW-1:0]  b;
    logic [N_RES*OW-1:0]   sum;

    // Sign-extend each pair to the level width and add.
    always_comb begin
        pad = '0;
        pad[N_OPS*IW-1:0] = in_bus;
        a   = '0;
        b   = '0;
        sum = '0;
        for (int k = 0; k < N_RES; k++) begin
            a = pad[2*k*IW +: IW];
            b = pad[(2*k+1)*IW +: IW];
            sum[k*OW +: OW] = OW'(a) + OW'(b);
        end
    end

    // Data register; contents are qualified by the valid flag.
    always_ff @(posedge clk) begin
        out_bus <= sum;
    end

    // Beat flags travel with the data and are cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_vld   <= in_vld;
            out_first <= in_first;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined signed adder tree over N_IN lanes plus bias, followed by a
// multi-beat accumulator and a saturating/wrapping output register.
module add_tree_pipe
    import add_tree_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DW     = DW_DEF,
    parameter int SAT    = SAT_DEF,
    parameter int ACC_GW = ACC_GW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [N_IN*DW-1:0]     in_bus,
    input  logic signed [DW-1:0]   in_bias,
    output logic signed [DW-1:0]   out,
    output logic                   out_vld,
    output logic                   ovf
);

    localparam int M  = N_IN + 1;
    localparam int L  = clog2(M);
    localparam int TW = DW + L;
    localparam int AW = TW + ACC_GW;
    localparam int FW = tree_off(M, DW, L + 1);

    wire [FW-1:0] tree_flat;
    wire [L:0]    vld_t;
    wire [L:0]    first_t;
    wire [L:0]    last_t;

    // Level 0: bias rides as the topmost lane.
    assign tree_flat[M*DW-1:0] = {in_bias, in_bus};
    assign vld_t[0]   = in_vld;
    assign first_t[0] = in_first;
    assign last_t[0]  = in_last;

    // Levels 1..L: each one bit wider, roughly half the operands.
    for (genvar j = 1; j <= L; j++) begin : g_lvl
        add_tree_level #(
            .N_OPS (ops_at(M, j - 1)),
            .IW    (DW + j - 1)
        ) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .in_vld    (vld_t[j-1]),
            .in_first  (first_t[j-1]),
            .in_last   (last_t[j-1]),
            .in_bus    (tree_flat[tree_off(M, DW, j-1) +: ops_at(M, j-1)*(DW+j-1)]),
            .out_vld   (vld_t[j]),
            .out_first (first_t[j]),
            .out_last  (last_t[j]),
            .out_bus   (tree_flat[tree_off(M, DW, j) +: ops_at(M, j)*(DW+j)])
        );
    end

    // ---- tree output (stage p0) ----
    logic signed [TW-1:0] sum_p0;
    assign sum_p0 = tree_flat[FW-1 -: TW];

    // ---- accumulator (stage p1) ----
    logic signed [AW-1:0] acc_p1;
    logic                 vld_p1;
    logic                 last_p1;

    // First beat loads, later beats add; idle stages leave the sum alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p1  <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_t[L];
            last_p1 <= last_t[L];
            if (vld_t[L]) begin
                if (first_t[L]) acc_p1 <= AW'(sum_p0);
                else            acc_p1 <= acc_p1 + AW'(sum_p0);
            end
        end
    end

    // ---- output register (stage p2) ----
    logic [64:0] cv;
    assign cv = conv_out(128'(acc_p1), DW, SAT != 0);

    if (DW < 64) begin : g_cv_hi
        logic [63-DW:0] cv_hi_unused;
        assign cv_hi_unused = cv[63:DW];
    end

    // Publish the converted group result on its last beat; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            ovf     <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= vld_p1 & last_p1;
            if (vld_p1 && last_p1) begin
                out <= cv[DW-1:0];
                ovf <= cv[64];
            end
        end
    end

endmodule

// File: tb/tb_add_tree_pipe.sv
// Bench for add_tree_pipe: default saturating and wrapping instances share
// stimulus; a small N_IN=4, DW=8 instance checks the reduced geometry.
module tb_add_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_vld, in_first, in_last;
    logic [399:0] in_bus;
    logic [15:0] in_bias;
    logic [15:0] out_a, out_w;
    logic        vld_a, vld_w, ovf_a, ovf_w;

    logic        s_vld, s_first, s_last;
    logic [31:0] s_bus;
    logic [7:0]  s_bias;
    logic [7:0]  s_out;
    logic        s_ovld, s_ovf;

    add_tree_pipe #(.N_IN(25), .DW(16), .SAT(1), .ACC_GW(8)) dut_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_first(in_first), .in_last(in_last),
        .in_bus(in_bus), .in_bias(in_bias), .out(out_a), .out_vld(vld_a), .ovf(ovf_a));

    add_tree_pipe #(.N_IN(25), .DW(16), .SAT(0), .ACC_GW(8)) dut_wrap (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_first(in_first), .in_last(in_last),
        .in_bus(in_bus), .in_bias(in_bias), .out(out_w), .out_vld(vld_w), .ovf(ovf_w));

    add_tree_pipe #(.N_IN(4), .DW(8), .SAT(1), .ACC_GW(8)) dut_small (
        .clk(clk), .rst(rst), .in_vld(s_vld), .in_first(s_first), .in_last(s_last),
        .in_bus(s_bus), .in_bias(s_bias), .out(s_out), .out_vld(s_ovld), .ovf(s_ovf));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] s;
        logic        os;
        logic [15:0] w;
        logic        ow;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0] v;
        logic       o;
        int         cyc;
    } exps_t;

    typedef struct {
        int                 pat;
        logic signed [15:0] v0;
        logic signed [15:0] bias;
        logic [15:0]        s;
        logic               os;
        logic [15:0]        w;
        logic               ow;
    } vec_t;

    exp_t  q[$];
    exps_t qs[$];
    vec_t  tab [9];
    logic signed [15:0] lanes [25];
    longint acc_m = 0;
    logic [15:0] last_a = '0, last_w = '0;
    logic        lovf_a = 1'b0, lovf_w = 1'b0;
    logic [7:0]  last_s = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] sat16(input longint v);
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    function automatic logic [16:0] wrap16(input longint v);
        logic signed [15:0] lo;
        longint b;
        lo = v[15:0];
        b  = lo;
        return {(b != v), lo};
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e = '{v.s, v.os, v.w, v.ow, 0};
        return e;
    endfunction

    task automatic fill(input int pat, input logic signed [15:0] v0);
        for (int k = 0; k < 25; k++) begin
            case (pat)
                0: lanes[k] = 16'(k);
                1: lanes[k] = 16'(-k);
                2: lanes[k] = (k < 13) ? 16'(-k) : 16'(k);
                3: lanes[k] = 16'h7FFF;
                4: lanes[k] = 16'h8000;
                5: lanes[k] = 16'h0000;
                6: lanes[k] = (k == 0) ? v0 : 16'sd0;
                default: lanes[k] = 16'($urandom_range(0, 4000)) - 16'sd2000;
            endcase
        end
    endtask

    task automatic beat(input logic f, input logic l, input logic signed [15:0] bias,
                        input logic use_tab, input exp_t te);
        longint s;
        exp_t e;
        logic [16:0] rs, rw;
        @(posedge clk); #1;
        s_vld = 1'b0; s_first = 1'b0; s_last = 1'b0;
        in_vld = 1'b1; in_first = f; in_last = l; in_bias = bias;
        s = bias;
        for (int k = 0; k < 25; k++) begin
            in_bus[k*16 +: 16] = lanes[k];
            s = s + lanes[k];
        end
        acc_m = f ? s : acc_m + s;
        if (l) begin
            if (use_tab) e = te;
            else begin
                rs = sat16(acc_m);
                rw = wrap16(acc_m);
                e = '{rs[15:0], rs[16], rw[15:0], rw[16], 0};
            end
            e.cyc = cyc + 7;
            q.push_back(e);
        end
    endtask

    task automatic sbeat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] bias,
                         input logic [7:0] v, input logic o);
        exps_t e;
        @(posedge clk); #1;
        in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
        s_vld = 1'b1; s_first = 1'b1; s_last = 1'b1;
        s_bus = {d, c, b, a}; s_bias = bias;
        e = '{v, o, cyc + 5};
        qs.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0;
            s_vld = 1'b0; s_first = 1'b0; s_last = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() > 0 || qs.size() > 0); i++) idle(1);
        chk("drain_main", q.size(), 0);
        chk("drain_small", qs.size(), 0);
    endtask

    // Scoreboard for the two default-geometry instances.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vld_a || vld_w) begin
                if (q.size() == 0) begin
                    chk("spurious_vld", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("vld_sat", vld_a, 1);
                    chk("vld_wrap", vld_w, 1);
                    chk("out_sat", out_a, e.s);
                    chk("ovf_sat", ovf_a, e.os);
                    chk("out_wrap", out_w, e.w);
                    chk("ovf_wrap", ovf_w, e.ow);
                    chk("latency", cyc, e.cyc);
                    last_a = e.s; lovf_a = e.os;
                    last_w = e.w; lovf_w = e.ow;
                end
            end else begin
                chk("hold_sat", out_a, last_a);
                chk("hold_ovf_sat", ovf_a, lovf_a);
                chk("hold_wrap", out_w, last_w);
                chk("hold_ovf_wrap", ovf_w, lovf_w);
            end
        end
    end

    // Scoreboard for the small instance.
    always @(negedge clk) begin
        exps_t e;
        if (!rst) begin
            if (s_ovld) begin
                if (qs.size() == 0) begin
                    chk("spurious_vld_small", 1, 0);
                end else begin
                    e = qs.pop_front();
                    chk("out_small", s_out, e.v);
                    chk("ovf_small", s_ovf, e.o);
                    chk("latency_small", cyc, e.cyc);
                    last_s = e.v;
                end
            end else begin
                chk("hold_small", s_out, last_s);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t none;
        exp_t t;
        int   n;
        logic signed [15:0] rb;
        none = '{16'h0, 1'b0, 16'h0, 1'b0, 0};

        tab[0] = '{0, 16'sd0,      16'sd25,     16'h0145, 1'b0, 16'h0145, 1'b0};
        tab[1] = '{1, 16'sd0,      -16'sd25,    16'hFEBB, 1'b0, 16'hFEBB, 1'b0};
        tab[2] = '{2, 16'sd0,      16'sd25,     16'h00A9, 1'b0, 16'h00A9, 1'b0};
        tab[3] = '{3, 16'sd0,      16'sh7FFF,   16'h7FFF, 1'b1, 16'hFFE6, 1'b1};
        tab[4] = '{4, 16'sd0,      16'sh8000,   16'h8000, 1'b1, 16'h0000, 1'b1};
        tab[5] = '{5, 16'sd0,      16'sd0,      16'h0000, 1'b0, 16'h0000, 1'b0};
        tab[6] = '{6, 16'sh7FFF,   16'sd0,      16'h7FFF, 1'b0, 16'h7FFF, 1'b0};
        tab[7] = '{6, 16'sh7FFF,   16'sd1,      16'h7FFF, 1'b1, 16'h8000, 1'b1};
        tab[8] = '{6, 16'sh8000,   -16'sd1,     16'h8000, 1'b1, 16'h7FFF, 1'b1};

        rst = 1'b1;
        in_vld = 1'b0; in_first = 1'b0; in_last = 1'b0; in_bus = '0; in_bias = '0;
        s_vld = 1'b0; s_first = 1'b0; s_last = 1'b0; s_bus = '0; s_bias = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_sat", out_a, 0);
        chk("rst_vld_sat", vld_a, 0);
        chk("rst_ovf_sat", ovf_a, 0);
        chk("rst_out_wrap", out_w, 0);
        chk("rst_vld_wrap", vld_w, 0);
        chk("rst_ovf_wrap", ovf_w, 0);
        chk("rst_out_small", s_out, 0);
        chk("rst_vld_small", s_ovld, 0);
        chk("rst_ovf_small", s_ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-beat vectors, back to back.
        for (int i = 0; i < 9; i++) begin
            fill(tab[i].pat, tab[i].v0);
            beat(1'b1, 1'b1, tab[i].bias, 1'b1, to_exp(tab[i]));
        end
        idle(1);

        // Three-beat group.
        t = '{16'h03CF, 1'b0, 16'h03CF, 1'b0, 0};
        fill(0, 16'sd0);
        beat(1'b1, 1'b0, 16'sd25, 1'b0, none);
        beat(1'b0, 1'b0, 16'sd25, 1'b0, none);
        beat(1'b0, 1'b1, 16'sd25, 1'b1, t);
        idle(2);

        // Open group discarded by a new first beat.
        fill(3, 16'sd0);
        beat(1'b1, 1'b0, 16'sh7FFF, 1'b0, none);
        fill(0, 16'sd0);
        beat(1'b1, 1'b1, 16'sd25, 1'b1, to_exp(tab[0]));
        idle(1);

        // Idle cycles inside a group do not disturb the accumulator.
        t = '{16'h028A, 1'b0, 16'h028A, 1'b0, 0};
        beat(1'b1, 1'b0, 16'sd25, 1'b0, none);
        idle(3);
        beat(1'b0, 1'b1, 16'sd25, 1'b1, t);
        idle(1);

        // Random groups against the bench model.
        repeat (20) begin
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) begin
                fill(7, 16'sd0);
                rb = 16'($urandom_range(0, 4000)) - 16'sd2000;
                beat(b == 0, b == n - 1, rb, 1'b0, none);
            end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        drain();

        // Reset three cycles after a valid beat drops it.
        fill(0, 16'sd0);
        beat(1'b1, 1'b1, 16'sd25, 1'b0, none);
        idle(3);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete(); qs.delete(); acc_m = 0;
        last_a = '0; last_w = '0; lovf_a = 1'b0; lovf_w = 1'b0; last_s = '0;
        in_vld = 1'b0;
        @(negedge clk);
        chk("midrst_out", out_a, 0);
        chk("midrst_vld", vld_a, 0);
        chk("midrst_ovf", ovf_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);

        // Group opening without in_first after reset accumulates onto zero.
        beat(1'b0, 1'b1, 16'sd25, 1'b1, to_exp(tab[0]));
        fill(1, 16'sd0);
        beat(1'b1, 1'b1, -16'sd25, 1'b1, to_exp(tab[1]));
        idle(1);
        drain();

        // Reduced geometry: N_IN=4, DW=8.
        sbeat(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd15, 1'b0);
        sbeat(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'h7F, 1'b1);
        sbeat(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
        sbeat(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hF1, 1'b0);
        idle(1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
